// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the multi-port register file and its clear sequencer.
package reg_file_pkg;

  typedef enum logic {CLEAR, RUN} rf_state_t;

  localparam int unsigned LANE_W = 8;

  // Number of byte lanes in a word of width dw.
  function automatic int unsigned be_w(input int unsigned dw);
    return dw / LANE_W;
  endfunction

  // Width-generic byte merge is built lane by lane from this helper in the top.
  function automatic logic [LANE_W-1:0] byte_merge(input logic [LANE_W-1:0] old_w,
                                                   input logic [LANE_W-1:0] new_w,
                                                   input logic             be);
    return be ? new_w : old_w;
  endfunction

endpackage

// File: rtl/reg_file_clr_fsm.sv
// Post-reset clear sequencer: walks every address writing zero, then raises ready.
module reg_file_clr_fsm
  import reg_file_pkg::*;
#(
  parameter int unsigned ADD_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 ready,
  output logic                 clr_en,
  output logic [ADD_WIDTH-1:0] clr_add
);

  localparam logic [ADD_WIDTH-1:0] LAST_ADD = '1;

  rf_state_t            state_q, state_d;
  logic [ADD_WIDTH-1:0] clr_ptr_q, clr_ptr_d;
  logic                 ready_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      // ready trails RUN by one edge so it rises on edge DEPTH+1 after reset release
      ready_q   <= (state_q == RUN);
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    clr_en    = 1'b0;
    unique case (state_q)
      CLEAR: begin
        clr_en = 1'b1;
        if (clr_ptr_q == LAST_ADD) begin
          state_d   = RUN;
          clr_ptr_d = '0;
        end else begin
          clr_ptr_d = clr_ptr_q + 1'b1;
        end
      end
      RUN: ;
      default: state_d = CLEAR;
    endcase
  end

  assign ready   = ready_q;
  assign clr_add = clr_ptr_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: one byte-enabled write port, NUM_RD read ports,
// combinational or registered reads with optional write-first bypass.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int unsigned ADD_WIDTH  = 3,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_RD     = 2,
  parameter int unsigned REG_RD     = 1,
  parameter int unsigned BYPASS     = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           w_en,
  input  logic [ADD_WIDTH-1:0]           w_add,
  input  logic [DATA_WIDTH-1:0]          w_data,
  input  logic [DATA_WIDTH/8-1:0]        w_be,
  input  logic [NUM_RD-1:0]              r_en,
  input  logic [NUM_RD*ADD_WIDTH-1:0]    r_add,
  output logic [NUM_RD*DATA_WIDTH-1:0]   r_data,
  output logic                           ready
);

  localparam int unsigned DEPTH = 2 ** ADD_WIDTH;
  localparam int unsigned BE_W  = be_w(DATA_WIDTH);

  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH == 0) begin : g_bad_dw
    $error("reg_file_mp: DATA_WIDTH must be a non-zero multiple of 8");
  end
  if (NUM_RD < 1) begin : g_bad_nrd
    $error("reg_file_mp: NUM_RD must be at least 1");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  clr_en;
  logic [ADD_WIDTH-1:0]  clr_add;
  logic                  wr_fire;
  logic [DATA_WIDTH-1:0] wr_old, wr_merged;

  reg_file_clr_fsm #(
    .ADD_WIDTH (ADD_WIDTH)
  ) u_clr_fsm (
    .clk     (clk),
    .reset   (reset),
    .ready   (ready),
    .clr_en  (clr_en),
    .clr_add (clr_add)
  );

  assign wr_fire = ready & w_en & ~reset;
  assign wr_old  = mem[w_add];

  always_comb begin
    wr_merged = '0;
    for (int unsigned i = 0; i < BE_W; i++) begin
      wr_merged[i*8 +: 8] = byte_merge(wr_old[i*8 +: 8], w_data[i*8 +: 8], w_be[i]);
    end
  end

  // Clear writes own the array until ready; user writes are only honoured afterwards.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem[clr_add] <= '0;
    end else if (wr_fire) begin
      mem[w_add] <= wr_merged;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADD_WIDTH-1:0] ra;
    assign ra = r_add[k*ADD_WIDTH +: ADD_WIDTH];

    if (REG_RD != 0) begin : g_reg
      logic [DATA_WIDTH-1:0] q;
      logic                  hit;

      assign hit = (BYPASS != 0) && wr_fire && (w_add == ra);

      always_ff @(posedge clk) begin
        if (reset) begin
          q <= '0;
        end else if (ready && r_en[k]) begin
          q <= hit ? wr_merged : mem[ra];
        end
      end

      assign r_data[k*DATA_WIDTH +: DATA_WIDTH] = q;
    end else begin : g_comb
      assign r_data[k*DATA_WIDTH +: DATA_WIDTH] = ready ? mem[ra] : '0;
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Randomised scoreboard bench for reg_file_mp (registered reads, write-first bypass, 16-bit words).
module tb_reg_file_mp;

  localparam int unsigned AW    = 3;
  localparam int unsigned DW    = 16;
  localparam int unsigned NR    = 2;
  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned BEW   = DW / 8;

  logic               clk = 1'b0;
  logic               reset;
  logic               w_en;
  logic [AW-1:0]      w_add;
  logic [DW-1:0]      w_data;
  logic [BEW-1:0]     w_be;
  logic [NR-1:0]      r_en;
  logic [NR*AW-1:0]   r_add;
  logic [NR*DW-1:0]   r_data;
  logic               ready;

  reg_file_mp #(
    .ADD_WIDTH  (AW),
    .DATA_WIDTH (DW),
    .NUM_RD     (NR),
    .REG_RD     (1),
    .BYPASS     (1)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .w_en   (w_en),
    .w_add  (w_add),
    .w_data (w_data),
    .w_be   (w_be),
    .r_en   (r_en),
    .r_add  (r_add),
    .r_data (r_data),
    .ready  (ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic               rdy;
    logic [NR-1:0][DW-1:0] rd;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: contents, reads held per port, edges since reset release.
  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] m_rd  [NR];
  int            m_cnt = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
  endtask

  // Drive one cycle of stimulus and push the state the DUT must show after the edge.
  task automatic drive(input logic rst, input logic we, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic [BEW-1:0] wbe,
                       input logic [NR-1:0] ren, input logic [AW-1:0] ra0,
                       input logic [AW-1:0] ra1);
    logic          pre_ready;
    logic [DW-1:0] mask, new_w;
    logic [AW-1:0] ra [NR];
    exp_t          e;
    @(negedge clk);
    reset  = rst;  w_en = we;  w_add = wa;  w_data = wd;  w_be = wbe;
    r_en   = ren;  r_add = {ra1, ra0};
    ra[0] = ra0;  ra[1] = ra1;
    pre_ready = (m_cnt >= DEPTH + 1);
    if (rst) begin
      m_cnt = 0;
      for (int i = 0; i < NR; i++) m_rd[i] = '0;
      for (int a = 0; a < DEPTH; a++) m_mem[a] = '0;
    end else begin
      mask = '0;
      for (int i = 0; i < BEW; i++) if (wbe[i]) mask = mask | (DW'(16'hFF) << (8 * i));
      new_w = (m_mem[wa] & ~mask) | (wd & mask);
      for (int k = 0; k < NR; k++)
        if (pre_ready && ren[k])
          m_rd[k] = (we && wa == ra[k]) ? new_w : m_mem[ra[k]];
      if (pre_ready && we) m_mem[wa] = new_w;
      if (m_cnt < 1000) m_cnt++;
    end
    e.rdy = !rst && (m_cnt >= DEPTH + 1);
    for (int k = 0; k < NR; k++) e.rd[k] = m_rd[k];
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0, '0, '0, '0, '0);
  endtask

  // Monitor: compare after every edge for which the driver queued an expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("ready", DW'(ready), DW'(e.rdy));
        for (int k = 0; k < NR; k++)
          chk($sformatf("r_data[%0d]", k), r_data[k*DW +: DW], e.rd[k]);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [AW-1:0] wa, ra0, ra1;
    reset = 1'b1; w_en = 1'b0; w_add = '0; w_data = '0; w_be = '0; r_en = '0; r_add = '0;

    // Reset, then a write attempted during clear must be dropped.
    drive(1'b1, 0, 0, 0, 0, 0, 0, 0);
    drive(1'b1, 0, 0, 0, 0, 0, 0, 0);
    drive(1'b0, 1, 3'd3, 16'h00A5, 2'b11, 2'b11, 3'd3, 3'd3);
    idle(8);
    for (int a = 0; a < DEPTH; a += 2) drive(0, 0, 0, 0, 0, 2'b11, AW'(a), AW'(a + 1));

    // Plain write, then read back.
    drive(0, 1, 3'd3, 16'h005A, 2'b11, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 2'b11, 3'd3, 3'd0);

    // Byte-lane enables.
    drive(0, 1, 3'd5, 16'h1234, 2'b11, 0, 0, 0);
    drive(0, 1, 3'd5, 16'hABCD, 2'b10, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 2'b01, 3'd5, 3'd0);
    drive(0, 0, 3'd5, 16'hFFFF, 2'b00, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 2'b10, 3'd0, 3'd5);

    // Same-edge collision with bypass, then the other port next edge.
    drive(0, 1, 3'd2, 16'h0011, 2'b11, 0, 0, 0);
    drive(0, 1, 3'd2, 16'h0077, 2'b01, 2'b01, 3'd2, 3'd0);
    drive(0, 0, 0, 0, 0, 2'b10, 3'd0, 3'd2);

    // Port 1 disabled while its address moves; port 0 keeps reading.
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 2'b01, AW'(i + 3), AW'(i + 4));

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      wa  = AW'($urandom_range(DEPTH - 1));
      ra0 = ($urandom_range(3) == 0) ? wa : AW'($urandom_range(DEPTH - 1));
      ra1 = ($urandom_range(3) == 0) ? wa : AW'($urandom_range(DEPTH - 1));
      drive(($urandom_range(79) == 0), ($urandom_range(1) == 1), wa, DW'($urandom),
            BEW'($urandom), NR'($urandom), ra0, ra1);
    end

    // Reset while populated: clear reruns and every entry reads zero again.
    idle(10);
    for (int a = 0; a < DEPTH; a++) drive(0, 1, AW'(a), DW'($urandom) | 16'h0101, 2'b11, 0, 0, 0);
    drive(1'b1, 0, 0, 0, 0, 0, 0, 0);
    idle(9);
    for (int a = 0; a < DEPTH; a += 2) drive(0, 0, 0, 0, 0, 2'b11, AW'(a), AW'(a + 1));

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-port register file: one write port with byte enables and N independent read ports. Read ports are selectable at elaboration as combinational or registered, with optional write-to-read bypass. After every reset, a built-in clear sequencer zeroes the whole array and then asserts ready. It is the storage core for the next-generation FIFOs and the small CSR/scratch banks in the datapath.

Parameters:
ADD_WIDTH, 3, address width; DEPTH = 2**ADD_WIDTH entries.
DATA_WIDTH, 8, word width; must be a multiple of 8 (elaboration-time assertion).
NUM_RD, 2, number of read ports (>=1).
REG_RD, 1, 1 = registered reads (latency 1); 0 = combinational reads (latency 0).
BYPASS, 1, REG_RD=1 only: 1 = write-first on same-address collision, 0 = read-first.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-high reset.
w_en  in  1  write request.
w_add  in  ADD_WIDTH  write address.
w_data  in  DATA_WIDTH  write data.
w_be  in  DATA_WIDTH/8  byte-lane enables; bit i covers w_data[8i+7:8i].
r_en  in  NUM_RD  per-port read enable (REG_RD=1 only; ignored otherwise).
r_add  in  NUM_RD*ADD_WIDTH  packed; port k uses bits [k*ADD_WIDTH +: ADD_WIDTH].
r_data  out  NUM_RD*DATA_WIDTH  packed; port k uses bits [k*DATA_WIDTH +: DATA_WIDTH].
ready  out  1  high once clearing is complete; writes and reads are accepted only when high.

Behaviour:
- FSM states: CLEAR, RUN. Reset forces CLEAR with clr_ptr=0, ready=0, all registered r_data=0.
- CLEAR: each cycle writes 0 to mem[clr_ptr] and increments clr_ptr. On the cycle clr_ptr==DEPTH-1 the FSM moves to RUN. ready goes high on the (DEPTH+1)th rising edge after reset is sampled low (edge 9 for DEPTH=8).
- Reset asserted during CLEAR or RUN restarts CLEAR from address 0. There is no partial-state retention.
- w_en while ready=0 is dropped silently; memory is unchanged apart from the clear writes.
- Write in RUN: on the edge where w_en=1, mem[w_add] lane i takes w_data lane i where w_be[i]=1. Other lanes hold. w_be=0 means no change.
- REG_RD=1:
  - r_data[k] updates on the edge where ready & r_en[k]; otherwise it holds its last value.
  - While ready=0, r_data stays 0.
- Collision, REG_RD=1 (w_en & r_en[k] & w_add==r_add[k], same edge):
  - BYPASS=1: r_data[k] = byte-merged result (new lanes where w_be set, old lanes elsewhere).
  - BYPASS=0: r_data[k] = pre-write contents.
- REG_RD=0:
  - r_data[k] = mem[r_add[k]] combinationally, and is forced to 0 while ready=0.
  - A write becomes visible after the write edge. BYPASS has no effect.
- Multiple read ports may address the same entry; each is served independently.
- Address arithmetic: clr_ptr is ADD_WIDTH+1 bits wide, or the terminal compare is used, so there is no wrap-around glitch.
- X-free: no output is ever X after the first reset edge.

Decomposition:
- Package reg_file_pkg holds:
  - typedef enum logic {CLEAR, RUN} rf_state_t;
  - function byte_merge(old, new, be), parametrised via let/width-generic constants;
  - localparam BE_W = DATA_WIDTH/8 helper.
- One natural sub-module, reg_file_clr_fsm: state register, clr_ptr, ready, and the clear write address/enable. The top muxes clear writes against user writes.
- The array and read ports stay in the top, using a generate loop over NUM_RD.

Test Plan:
1. Reset for 2 cycles, then release (DEPTH=8) -> ready=0 for 8 edges and 1 on edge 9; a subsequent read of every address returns 0x00.
2. Write 0xA5 at addr 3 before ready, then after ready read addr 3 -> 0x00 (write dropped). Write 0x5A at addr 3 in RUN, read one cycle later -> 0x5A.
3. DATA_WIDTH=16: write 0x1234 with be=11, then write 0xABCD with be=10 at addr 5 -> read returns 0xAB34.
4. REG_RD=1, BYPASS=1: same edge write 0x77 to addr 2 and read port 0 at addr 2 (old 0x11) -> r_data[0]=0x77. With BYPASS=0 -> 0x11. Port 1 reading addr 2 on the next edge -> 0x77.
5. Assert r_en[1]=0 for 3 cycles while r_add[1] changes -> r_data[1] holds its value. Port 0 tracks its reads independently.
6. Assert reset for 1 cycle when ready=1 and memory is populated -> ready drops, r_data=0, clear reruns for 8 cycles, and all entries read 0x00 afterwards.
